// File: rtl/emd_pkg.sv
// Shared types and constants for the EMD sifting controller: event type codes,
// the control FSM state encoding and default sample/index widths.
package emd_pkg;

  localparam int DW_DEF = 16;
  localparam int TW_DEF = 16;

  localparam logic [1:0] EV_MAX   = 2'b00;
  localparam logic [1:0] EV_MIN   = 2'b01;
  localparam logic [1:0] EV_START = 2'b10;
  localparam logic [1:0] EV_END   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/emd_extremum_cmp.sv
// Combinational strict local-extremum test of the middle sample B against its
// neighbours A and C; signed, full width. Plateaus are neither max nor min.
module emd_extremum_cmp #(
  parameter int DW = emd_pkg::DW_DEF
) (
  input  logic signed [DW-1:0] A,
  input  logic signed [DW-1:0] B,
  input  logic signed [DW-1:0] C,
  output logic                 is_max,
  output logic                 is_min
);

  assign is_max = (B > A) && (B > C);
  assign is_min = (B < A) && (B < C);

endmodule

// File: rtl/emd_sift_ctrl.sv
// Streams one frame of samples, emitting start/extremum/end events through a
// single-entry event register; minima detection is built only with EMD_MIN_DETECT_EN.
module emd_sift_ctrl #(
  parameter int DW = emd_pkg::DW_DEF,
  parameter int TW = emd_pkg::TW_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic [TW-1:0]        FrameLen,
  input  logic                 In_valid,
  output logic                 In_ready,
  input  logic signed [DW-1:0] In_data,
  output logic                 Ev_valid,
  input  logic                 Ev_ready,
  output logic [TW-1:0]        Ev_time,
  output logic signed [DW-1:0] Ev_data,
  output logic [1:0]           Ev_type,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err,
  output logic [TW-1:0]        Max_cnt,
  output logic [TW-1:0]        Min_cnt
);
  import emd_pkg::*;

  state_e               state_q, state_d;
  logic [TW-1:0]        len_q, idx_q, max_cnt_q;
  logic signed [DW-1:0] a_q, b_q, c_q;
  logic                 ev_vld_q;
  logic [TW-1:0]        ev_time_q;
  logic signed [DW-1:0] ev_data_q;
  logic [1:0]           ev_type_q;
  logic                 done_q, err_q;

  logic                 ev_free, start_ok, start_bad, xfer, flush_load, end_hs;
  logic                 is_max, is_min, min_hit, cls_en, max_ev, min_ev;
  logic                 ev_load;
  logic [1:0]           ev_type_d;
  logic [TW-1:0]        ev_time_d;
  logic signed [DW-1:0] ev_data_d;

  // The incoming sample is C; the window registers still hold indices k-2, k-1.
  emd_extremum_cmp #(.DW(DW)) u_cmp (
    .A      (b_q),
    .B      (c_q),
    .C      (In_data),
    .is_max (is_max),
    .is_min (is_min)
  );

`ifdef EMD_MIN_DETECT_EN
  assign min_hit = is_min;
`else
  logic unused_min;
  assign unused_min = is_min;
  assign min_hit    = 1'b0;
`endif

  assign ev_free = !ev_vld_q || Ev_ready;

  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    xfer       = 1'b0;
    flush_load = 1'b0;
    end_hs     = 1'b0;
    In_ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (FrameLen >= TW'(3)) begin
            start_ok = 1'b1;
            state_d  = S_RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_RUN: begin
        In_ready = ev_free;
        xfer     = In_valid && ev_free;
        if (xfer && (idx_q == len_q - TW'(1))) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (ev_free) begin
          flush_load = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (ev_vld_q && Ev_ready) begin
          end_hs  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cls_en    = xfer && (idx_q >= TW'(2));
    max_ev    = cls_en && is_max;
    min_ev    = cls_en && min_hit;
    ev_load   = (xfer && (idx_q == '0)) || max_ev || min_ev || flush_load;
    ev_type_d = EV_START;
    ev_time_d = '0;
    ev_data_d = In_data;
    if (flush_load) begin
      ev_type_d = EV_END;
      ev_time_d = len_q - TW'(1);
      ev_data_d = c_q;
    end else if (max_ev) begin
      ev_type_d = EV_MAX;
      ev_time_d = idx_q - TW'(1);
      ev_data_d = c_q;
    end else if (min_ev) begin
      ev_type_d = EV_MIN;
      ev_time_d = idx_q - TW'(1);
      ev_data_d = c_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      len_q     <= '0;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      max_cnt_q <= '0;
      ev_vld_q  <= 1'b0;
      ev_time_q <= '0;
      ev_data_q <= '0;
      ev_type_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q  <= start_bad;
      done_q <= end_hs;
      if (start_ok) begin
        len_q     <= FrameLen;
        idx_q     <= '0;
        a_q       <= '0;
        b_q       <= '0;
        c_q       <= '0;
        max_cnt_q <= '0;
      end
      if (xfer) begin
        a_q   <= b_q;
        b_q   <= c_q;
        c_q   <= In_data;
        idx_q <= idx_q + TW'(1);
      end
      if (max_ev && (max_cnt_q != '1)) max_cnt_q <= max_cnt_q + TW'(1);
      // Fields are only rewritten on load so they hold while the consumer stalls.
      if (ev_load) begin
        ev_vld_q  <= 1'b1;
        ev_type_q <= ev_type_d;
        ev_time_q <= ev_time_d;
        ev_data_q <= ev_data_d;
      end else if (Ev_ready) begin
        ev_vld_q <= 1'b0;
      end
    end
  end

`ifdef EMD_MIN_DETECT_EN
  logic [TW-1:0] min_cnt_q;
  always_ff @(posedge CLK) begin
    if (RST)                                     min_cnt_q <= '0;
    else if (start_ok)                           min_cnt_q <= '0;
    else if (min_ev && (min_cnt_q != '1))        min_cnt_q <= min_cnt_q + TW'(1);
  end
  assign Min_cnt = min_cnt_q;
`else
  assign Min_cnt = '0;
`endif

  assign Ev_valid = ev_vld_q;
  assign Ev_time  = ev_time_q;
  assign Ev_data  = ev_data_q;
  assign Ev_type  = ev_type_q;
  assign Busy     = (state_q != S_IDLE);
  assign Done     = done_q;
  assign Err      = err_q;
  assign Max_cnt  = max_cnt_q;

endmodule
